kernel_sysid_checker: RTL and testbench

- Avalon-MM master sitting directly upstream of the system-ID slave; it consumes the slave's readdata.
- Reads word 0 (system ID) and then word 1 (build timestamp), and compares both against expected values.
- Publishes match/timeout status to the boot/health logic, so software or a reset sequencer can refuse to run a mismatched kernel image.
- Runs once automatically after reset and again on request.

---
 rtl/kernel_sysid_checker_pkg.sv | 9 +
 rtl/kernel_sysid_checker_if.sv | 10 +
 rtl/kernel_sysid_checker_read_port.sv | 40 ++++
 rtl/kernel_sysid_checker.sv | 89 ++++++++
 tb/tb_kernel_sysid_checker.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_sysid_checker_pkg.sv
// kernel_sysid_pkg: shared state encoding, word addresses and default expected values for the sysid checker.
package kernel_sysid_pkg;
  typedef enum logic [2:0] {IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE} state_e;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd1;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1531377617;
  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd255;
endpackage

// File: rtl/kernel_sysid_checker_if.sv
// kernel_sysid_checker_if: Avalon-MM read-only link between the checker (master) and the system-ID slave.
interface kernel_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;
  modport master (output avm_address, avm_read, input avm_waitrequest, avm_readdatavalid, avm_readdata);
  modport slave (input avm_address, avm_read, output avm_waitrequest, avm_readdatavalid, avm_readdata);
endinterface

// File: rtl/kernel_sysid_checker_read_port.sv
// kernel_sysid_read_port: one Avalon read at a time with a per-read timeout; go launches a new read.
module kernel_sysid_read_port #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        go,
  input  logic        addr,
  kernel_sysid_checker_if.master avm,
  output logic [31:0] data,
  output logic        valid,
  output logic        accepted,
  output logic        timed_out
);
  logic        active_q, rd_q, addr_q;
  logic [15:0] cnt_q;
  assign avm.avm_read    = rd_q;
  assign avm.avm_address = addr_q;
  assign data      = avm.avm_readdata;
  assign valid     = active_q & avm.avm_readdatavalid;
  assign accepted  = rd_q & ~avm.avm_waitrequest;
  // data arriving on the last allowed cycle beats the timeout
  assign timed_out = active_q & ~valid & (cnt_q == TIMEOUT_CYCLES - 16'd1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      active_q <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (go) begin
      active_q <= 1'b1;
      rd_q     <= 1'b1;
      addr_q   <= addr;
      cnt_q    <= '0;
    end else begin
      active_q <= active_q & ~valid & ~timed_out;
      rd_q     <= rd_q & ~accepted & ~valid & ~timed_out;
      cnt_q    <= active_q ? cnt_q + 16'd1 : cnt_q;
    end
endmodule

// File: rtl/kernel_sysid_checker.sv
// kernel_sysid_checker: reads the system ID and build timestamp words and publishes registered match/timeout status.
module kernel_sysid_checker
  import kernel_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter logic [15:0] TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  kernel_sysid_checker_if.master avm,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  state_e      state_q, state_d;
  logic        auto_q, req_q, go, addr, clr, id_phase;
  logic        valid, accepted, timed_out;
  logic [31:0] data, id_q, ts_q;
  logic        done_q, id_ok_q, ts_ok_q, timeout_q;
  kernel_sysid_read_port #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_port (
    .clock(clock), .reset_n(reset_n), .go(go), .addr(addr), .avm(avm),
    .data(data), .valid(valid), .accepted(accepted), .timed_out(timed_out)
  );
  assign busy     = state_q inside {REQ_ID, WAIT_ID, REQ_TS, WAIT_TS};
  assign id_phase = state_q inside {REQ_ID, WAIT_ID};
  assign clr      = go & (state_d == REQ_ID);
  assign {done, id_ok, ts_ok, timeout} = {done_q, id_ok_q, ts_ok_q, timeout_q};
  assign {id_value, ts_value} = {id_q, ts_q};
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    addr    = SYSID_ADDR_ID;
    case (state_q)
      IDLE, DONE: begin
        state_d = req_q ? REQ_ID : state_q;
        go      = req_q;
      end
      REQ_ID, WAIT_ID: begin
        state_d = valid ? REQ_TS : timed_out ? DONE : accepted ? WAIT_ID : state_q;
        go      = valid;
        addr    = SYSID_ADDR_TS;
      end
      REQ_TS, WAIT_TS: state_d = (valid | timed_out) ? DONE : accepted ? WAIT_TS : state_q;
      default: state_d = IDLE;
    endcase
  end
  // start is registered before launching, so the check begins one cycle after the request is seen
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      auto_q    <= AUTO_START;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= 1'b0;
      req_q   <= (start | auto_q) & ~busy;
      done_q  <= state_d == DONE;
      if (clr) begin
        id_ok_q   <= 1'b0;
        ts_ok_q   <= 1'b0;
        timeout_q <= 1'b0;
        id_q      <= '0;
        ts_q      <= '0;
      end else begin
        if (valid & id_phase) begin
          id_q    <= data;
          id_ok_q <= data == EXPECTED_ID;
        end
        if (valid & ~id_phase) begin
          ts_q    <= data;
          ts_ok_q <= data == EXPECTED_TIMESTAMP;
        end
        if (timed_out) timeout_q <= 1'b1;
      end
    end
endmodule

// File: tb/tb_kernel_sysid_checker.sv
// tb_kernel_sysid_checker: randomized slave plus scoreboard; expected results come from a latency/timeout model of each check.
module tb_kernel_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'd1;
  localparam logic [31:0] EXP_TS = 32'd1531377617;
  localparam int T     = 8;
  localparam int NEVER = 1000;
  typedef struct packed {
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] id_v;
    logic [31:0] ts_v;
    logic [31:0] rc_id;
    logic [31:0] rc_ts;
  } exp_t;
  logic clock = 1'b0, reset_n = 1'b1, start = 1'b0;
  logic busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  int compared = 0, mismatched = 0;
  exp_t sb[$];
  int cfg_w[2], cfg_d[2];
  logic [31:0] cfg_data[2];
  int pend = 0, stray = 0;
  int rc[2];
  kernel_sysid_checker_if avm();
  kernel_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .TIMEOUT_CYCLES(16'(T)), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(avm), .busy(busy), .done(done),
    .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // a read takes wait+1+delay cycles from first request to data; longer than T means timeout
  function automatic exp_t model();
    exp_t e;
    int lat[2];
    e = '0;
    for (int a = 0; a < 2; a++) lat[a] = (cfg_d[a] == NEVER) ? NEVER : cfg_w[a] + 1 + cfg_d[a];
    e.rc_id = (cfg_w[0] + 1 < T) ? cfg_w[0] + 1 : T;
    if (lat[0] > T) begin
      e.to = 1'b1;
      return e;
    end
    e.id_v  = cfg_data[0];
    e.id_ok = cfg_data[0] == EXP_ID;
    e.rc_ts = (cfg_w[1] + 1 < T) ? cfg_w[1] + 1 : T;
    if (lat[1] > T) e.to = 1'b1;
    else begin
      e.ts_v  = cfg_data[1];
      e.ts_ok = cfg_data[1] == EXP_TS;
    end
    return e;
  endfunction
  initial begin
    int wcnt = 0;
    int a;
    logic [31:0] pend_data = '0;
    avm.avm_waitrequest = 1'b0;
    avm.avm_readdatavalid = 1'b0;
    avm.avm_readdata = '0;
    forever begin
      @(negedge clock);
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata = $urandom;
      avm.avm_waitrequest = 1'b0;
      if (!reset_n) begin
        pend = 0;
        wcnt = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            avm.avm_readdatavalid = 1'b1;
            avm.avm_readdata = pend_data;
          end
        end
        if (avm.avm_read) begin
          a = int'(avm.avm_address);
          if (wcnt < cfg_w[a]) begin
            avm.avm_waitrequest = 1'b1;
            wcnt++;
          end else begin
            wcnt = 0;
            if (cfg_d[a] == 0) begin
              avm.avm_readdatavalid = 1'b1;
              avm.avm_readdata = cfg_data[a];
            end else if (cfg_d[a] != NEVER) begin
              pend = cfg_d[a];
              pend_data = cfg_data[a];
            end
          end
        end else wcnt = 0;
        if (stray > 0) begin
          stray--;
          avm.avm_readdatavalid = 1'b1;
          avm.avm_readdata = 32'h0BAD_F00D;
        end
      end
    end
  end
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        rc[0] = 0;
        rc[1] = 0;
        prev = 1'b0;
      end else begin
        if (avm.avm_read) rc[int'(avm.avm_address)]++;
        if (done && !prev) begin
          if (sb.size() == 0) check("done_without_request", 32'(sb.size()), 32'd1);
          else begin
            e = sb.pop_front();
            check("id_ok", id_ok, e.id_ok);
            check("ts_ok", ts_ok, e.ts_ok);
            check("timeout", timeout, e.to);
            check("id_value", id_value, e.id_v);
            check("ts_value", ts_value, e.ts_v);
            check("id_read_cycles", rc[0], e.rc_id);
            check("ts_read_cycles", rc[1], e.rc_ts);
            check("busy_in_done", busy, 0);
          end
          rc[0] = 0;
          rc[1] = 0;
        end
        prev = done;
      end
    end
  end
  task automatic set_cfg(input logic [31:0] idw, input logic [31:0] tsw, input int wi, input int di, input int wt, input int dt);
    cfg_data[0] = idw;
    cfg_data[1] = tsw;
    cfg_w[0] = wi;
    cfg_d[0] = di;
    cfg_w[1] = wt;
    cfg_d[1] = dt;
  endtask
  task automatic pulse_start;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask
  task automatic wait_done;
    int k = 0;
    repeat (2) @(negedge clock);
    while (!done && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("check_completes", done, 1);
    k = 0;
    while (pend != 0 && k < 50) begin
      @(negedge clock);
      k++;
    end
    repeat (2) @(negedge clock);
  endtask
  task automatic run(input logic [31:0] idw, input logic [31:0] tsw, input int wi, input int di, input int wt, input int dt, input bit lat);
    set_cfg(idw, tsw, wi, di, wt, dt);
    sb.push_back(model());
    pulse_start;
    if (lat) begin
      repeat (2) @(negedge clock);
      check("start_done_cycle3", done, 0);
      @(negedge clock);
      check("start_done_cycle4", done, 1);
    end
    wait_done;
  endtask
  initial begin
    int dtab[7] = '{0, 1, 2, 3, 7, 8, NEVER};
    int k;
    set_cfg(EXP_ID, EXP_TS, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_id_ok", id_ok, 0);
    check("rst_ts_ok", ts_ok, 0);
    check("rst_timeout", timeout, 0);
    check("rst_id_value", id_value, 0);
    check("rst_ts_value", ts_value, 0);
    check("rst_avm_read", avm.avm_read, 0);
    check("rst_avm_address", avm.avm_address, 0);
    sb.push_back(model());
    @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("auto_done_cycle3", done, 0);
    @(negedge clock);
    check("auto_done_cycle4", done, 1);
    wait_done;
    run(EXP_ID, EXP_TS, 0, 0, 0, 0, 1'b1);
    run(32'd2, EXP_TS, 0, 0, 0, 0, 1'b0);
    run(EXP_ID, EXP_TS, 0, 0, 3, 0, 1'b0);
    run(EXP_ID, EXP_TS, 0, NEVER, 0, 0, 1'b0);
    run(EXP_ID, EXP_TS, 0, 7, 0, 0, 1'b0);
    run(EXP_ID, EXP_TS, 0, 8, 0, 0, 1'b0);
    run(EXP_ID, 32'h1234, 1, 2, 0, NEVER, 1'b0);
    set_cfg(EXP_ID, EXP_TS, 0, 1, 3, 1);
    sb.push_back(model());
    pulse_start;
    @(negedge clock);
    check("busy_before_restart", busy, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done;
    run(EXP_ID, EXP_TS, 0, 1, 3, 1, 1'b0);
    set_cfg(EXP_ID, EXP_TS, 0, 0, 5, 0);
    pulse_start;
    k = 0;
    while (!(avm.avm_read && avm.avm_address) && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("ts_read_pending", avm.avm_read, 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_avm_read", avm.avm_read, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_id_ok", id_ok, 0);
    check("arst_id_value", id_value, 0);
    check("arst_timeout", timeout, 0);
    set_cfg(EXP_ID, EXP_TS, 0, 0, 0, 0);
    sb.push_back(model());
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    stray = 2;
    wait_done;
    repeat (24)
      run(($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_ID,
          ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_TS,
          $urandom_range(0, 3), dtab[$urandom_range(0, 6)],
          $urandom_range(0, 3), dtab[$urandom_range(0, 6)], 1'b0);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
